alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares the single combinational 16-bit ALU between two independent requesters (req0, req1).
- Arbitrates round-robin and registers the winning operands and opcode onto the ALU inputs.
- Holds the operation for an opcode-dependent number of cycles so MUL/DIV paths get multicycle timing. It then returns result, zero flag and error flag to the winner over a valid/ready response channel.
- Sits between the instruction-issue logic and the ALU instance.

## Interface
- MUL_CYCLES, 2, EXEC cycles for multiply (>=1)
- DIV_CYCLES, 4, EXEC cycles for divide (>=1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request N (N=0,1) presents operation
- reqN_ready  out  1  request N accepted on this edge when valid&ready
- reqN_a, reqN_b  in  16  operands
- reqN_op  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 or, 101 nor, 110 nand, 111 illegal
- respN_valid  out  1  response for requester N available
- respN_ready  in  1  requester N consumes response
- respN_result  out  16  captured result
- respN_zero  out  1  result == 0
- respN_err  out  1  illegal opcode or divide by zero
- alu_a, alu_b  out  16  ALU operands (registered)
- alu_op  out  3  ALU opcode (registered)
- alu_result  in  16  ALU combinational result

## Operation
- States:
  - IDLE: accepts a request.
  - EXEC: counts down the operation cycles.
  - RESP: holds the response until consumed.
- IDLE:
  - Grant is round-robin. With both valid, the requester not served last wins. With one valid, that one wins.
  - The last-served pointer resets to 1, so req0 wins the first tie.
  - reqN_ready = (state==IDLE) & grantN. It is combinational from the valids, and at most one ready is high.
- On acceptance, latch a, b, op and the owner ID, drive them to alu_a/alu_b/alu_op, load the counter with N-1, and enter EXEC.
  - N=1 for add/sub/or/nor/nand/illegal.
  - N=MUL_CYCLES for mul; N=DIV_CYCLES for div.
- EXEC: decrement each cycle. At count 0, capture the response on that edge, enter RESP and update the pointer to the owner.
- Capture rules:
  - Normal: result=alu_result, zero=(alu_result==0), err=0.
  - Illegal op (111): result=0, zero=0, err=1. The ALU value is ignored and alu_op stays at its latched value.
  - Div with b==0: result=16'hFFFF, zero=0, err=1. alu_result is ignored.
- The zero flag is computed locally from the captured result. The ALU's own flag is not used.
- RESP: respOwner_valid=1, the other resp_valid=0. When valid&ready on an edge, go to IDLE. respN_result/zero/err hold until the next capture.
- Reset, asynchronous and at any time including mid-EXEC or RESP:
  - State goes to IDLE and the in-flight operation is dropped. The requester must reissue.
  - All outputs go to 0: readys, resp_valids, results, flags, alu_a, alu_b, alu_op=000.
  - The pointer goes to 1.

## Timing
- Acceptance edge E0. Capture at edge E0+N. respN_valid is high from the cycle after E0+N.
- Earliest consumption is edge E0+N+1; the next acceptance is edge E0+N+2. Peak throughput is one op per N+2 cycles.
- reqN_ready is low in EXEC and RESP. A request held across those states waits; it is not lost.
- Same-cycle: valids changing while in EXEC have no effect. The response is not blocked by the other requester's valid.
- alu_a/alu_b/alu_op are stable for the whole EXEC window, so ALU paths get N cycles (multicycle constraint).

## Structure
- Package alu_ctrl_pkg:
  - Opcode constants OP_ADD..OP_NAND and OP_ILLEGAL.
  - State enum IDLE/EXEC/RESP.
  - Function op_cycles(op) returning N.
- Sub-module rr_arbiter_2: two valids plus the last pointer in, one-hot grant out. It is purely combinational; the pointer register lives in the parent.
- ALU instance external; alu_arbiter only drives its inputs.

## Test plan
- After reset, req0 add a=3 b=5 -> req0_ready at E0, resp0_valid at E0+2, result=8, zero=0, err=0.
- Both valid every cycle: req0 sub 7-7, req1 or 0|0 -> grants alternate 0,1,0,1. resp0 result=0 zero=1; resp1 result=0 zero=1.
- req1 div 100/7 with DIV_CYCLES=4 -> alu inputs stable 4 cycles, resp1 result=14 at E0+5. req1 div 5/0 -> result=FFFF, err=1, zero=0.
- req0 op=111 -> resp0 err=1, result=0, returned after N=1.
- Hold resp0_ready low for 10 cycles -> resp0_valid and data held, req1_ready stays 0. Raise ready -> IDLE, req1 granted 1 cycle later.
- Assert rst_n low mid-EXEC of a mul -> all outputs 0 asynchronously. After release, no response appears for the dropped op and req0 wins the next tie.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the ALU-sharing arbiter: datapath widths, opcode
// encodings, the controller state enum and the per-opcode EXEC length.
package alu_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB     = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL     = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV     = 3'b011;
  localparam logic [OP_W-1:0] OP_OR      = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR     = 3'b101;
  localparam logic [OP_W-1:0] OP_NAND    = 3'b110;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Number of cycles the operands are held on the ALU inputs for an opcode.
  // Multiply and divide get their configured multicycle windows, everything
  // else (including the illegal opcode) completes in one cycle.
  function automatic int unsigned op_cycles(input logic [OP_W-1:0] op,
                                            input int unsigned     mul_n,
                                            input int unsigned     div_n);
    int unsigned n;
    n = 1;
    if (op == OP_MUL) n = mul_n;
    if (op == OP_DIV) n = div_n;
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
// Two-way round-robin grant, purely combinational. The last-served pointer
// is held by the parent; this block only decides who wins this cycle.
//   valid0_i, valid1_i : requester valids
//   last_i             : index of the requester served most recently
//   grant_o            : one-hot grant (bit N = requester N), zero if none
module rr_arbiter_2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      // Tie goes to the requester that was not served last.
      grant_o = last_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational 16-bit ALU between two requesters.
// A round-robin winner's operands/opcode are registered onto the ALU inputs
// and held for an opcode-dependent number of cycles, then the result with
// zero/error flags is returned to the winner over a valid/ready channel.
//   clk, rst_n                       : clock, async active-low reset
//   reqN_valid/_ready/_a/_b/_op      : request channel of requester N
//   respN_valid/_ready/_result/_zero/_err : response channel of requester N
//   alu_a, alu_b, alu_op             : registered ALU inputs
//   alu_result                       : combinational ALU output
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,

  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  output logic              resp0_err,

  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
  output logic              resp1_err,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // Counter holds N-1 at most, so $clog2(CNT_MAX) bits suffice.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [1:0]         grant;
  logic [OP_W-1:0]    op_sel;
  logic               resp_rdy_sel;

  rr_arbiter_2 u_rr (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .grant_o  (grant)
  );

  assign op_sel       = grant[1] ? req1_op : req0_op;
  assign resp_rdy_sel = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          a_d     = grant[1] ? req1_a : req0_a;
          b_d     = grant[1] ? req1_b : req0_b;
          op_d    = op_sel;
          cnt_d   = CNT_W'(op_cycles(op_sel, MUL_CYCLES, DIV_CYCLES) - 1);
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (cnt_q == '0) begin
          // Error cases override the ALU value; zero is derived from the
          // captured result, so forced error results never flag zero.
          if (op_q == OP_ILLEGAL) begin
            res_d  = '0;
            zero_d = 1'b0;
            err_d  = 1'b1;
          end else if ((op_q == OP_DIV) && (b_q == '0)) begin
            res_d  = '1;
            zero_d = 1'b0;
            err_d  = 1'b1;
          end else begin
            res_d  = alu_result;
            zero_d = (alu_result == '0);
            err_d  = 1'b0;
          end
          last_d  = owner_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (resp_rdy_sel) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Readys are combinational from the valids; gating with rst_n keeps them
  // low while reset is asserted even if a requester holds valid high.
  assign req0_ready   = rst_n & (state_q == IDLE) & grant[0];
  assign req1_ready   = rst_n & (state_q == IDLE) & grant[1];

  assign resp0_valid  = (state_q == RESP) & ~owner_q;
  assign resp1_valid  = (state_q == RESP) &  owner_q;
  assign resp0_result = res_q;
  assign resp1_result = res_q;
  assign resp0_zero   = zero_q;
  assign resp1_zero   = zero_q;
  assign resp0_err    = err_q;
  assign resp1_err    = err_q;

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter: requests are driven just after the rising
// edge, a negedge monitor predicts readys and pops expected responses.
module tb_alu_arbiter;

  localparam int MUL_N = 2;
  localparam int DIV_N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [15:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero, resp0_err, resp1_err;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_zero(resp0_zero), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_zero(resp1_zero), .resp1_err(resp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  // External ALU; deliberately returns junk for div-by-zero and illegal ops.
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a * alu_b;
      3'd3: alu_result = (alu_b == 16'd0) ? 16'h1234 : alu_a / alu_b;
      3'd4: alu_result = alu_a | alu_b;
      3'd5: alu_result = ~(alu_a | alu_b);
      3'd6: alu_result = ~(alu_a & alu_b);
      default: alu_result = 16'hBEEF;
    endcase
  end

  typedef struct {
    int          who;
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        z, e;
    int          acc;
    int          n;
  } item_t;

  item_t sb[$];
  int    grant_log[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  bit    busy  = 0;
  bit    seen  = 0;
  int    last  = 1;
  bit    acc_flag [2];
  int    done_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference response from the opcode definitions using integer arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] res, output logic z, output logic e);
    int unsigned ua, ub, r;
    ua = a; ub = b; r = 0; e = 0;
    case (op)
      3'd0: r = (ua + ub) % 65536;
      3'd1: r = (ua + 65536 - ub) % 65536;
      3'd2: r = (ua * ub) % 65536;
      3'd3: if (ub == 0) begin r = 65535; e = 1; end else r = ua / ub;
      3'd4: r = ua | ub;
      3'd5: r = 65535 - (ua | ub);
      3'd6: r = 65535 - (ua & ub);
      default: begin r = 0; e = 1; end
    endcase
    res = r[15:0];
    z   = (r == 0) && !e;
  endfunction

  function automatic int cycles_of(input logic [2:0] op);
    if (op == 3'd2) return MUL_N;
    if (op == 3'd3) return DIV_N;
    return 1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard
  initial forever begin
    bit e0, e1, v, ov, rdy;
    item_t it, h;
    @(negedge clk);
    if (rst_n) begin
      e0 = 0; e1 = 0;
      if (!busy) begin
        if (req0_valid && req1_valid) begin
          if (last == 1) e0 = 1; else e1 = 1;
        end else if (req0_valid) e0 = 1;
        else if (req1_valid) e1 = 1;
      end
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);

      if (busy && sb.size() > 0) begin
        h   = sb[0];
        v   = h.who ? resp1_valid : resp0_valid;
        ov  = h.who ? resp0_valid : resp1_valid;
        rdy = h.who ? resp1_ready : resp0_ready;
        chk("resp_other_valid", ov, 0);
        if (!seen && cyc >= h.acc + h.n) chk("resp_due", v, 1);
        if (!v && !seen) begin
          chk("alu_a_hold", alu_a, h.a);
          chk("alu_b_hold", alu_b, h.b);
          chk("alu_op_hold", alu_op, h.op);
        end
        if (v) begin
          if (!seen) chk("resp_latency", cyc - h.acc, h.n);
          seen = 1;
          chk("resp_result", h.who ? resp1_result : resp0_result, h.res);
          chk("resp_zero", h.who ? resp1_zero : resp0_zero, h.z);
          chk("resp_err", h.who ? resp1_err : resp0_err, h.e);
          if (rdy) begin
            void'(sb.pop_front());
            busy = 0;
            seen = 0;
          end
        end
      end else begin
        chk("resp_spurious", {resp0_valid, resp1_valid}, 0);
      end

      if (e0 || e1) begin
        it.who = e1 ? 1 : 0;
        it.op  = e1 ? req1_op : req0_op;
        it.a   = e1 ? req1_a : req0_a;
        it.b   = e1 ? req1_b : req0_b;
        ref_op(it.op, it.a, it.b, it.res, it.z, it.e);
        it.acc = cyc + 1;
        it.n   = cycles_of(it.op);
        sb.push_back(it);
        grant_log.push_back(it.who);
        busy = 1;
        seen = 0;
        last = it.who;
        acc_flag[it.who] = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (who == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic issue(input int who, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    set_req(who, 1'b1, op, a, b);
    for (int i = 0; i < 200; i++) begin
      step();
      if (acc_flag[who]) begin
        acc_flag[who] = 0;
        set_req(who, 1'b0, op, a, b);
        return;
      end
    end
    chk("accept_timeout", who, who + 100);
    set_req(who, 1'b0, op, a, b);
  endtask

  task automatic model_reset();
    sb.delete();
    busy = 0; seen = 0; last = 1;
    acc_flag[0] = 0; acc_flag[1] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic rand_req(input int who);
    logic [2:0]  op;
    logic [15:0] a, b;
    op = 3'($urandom_range(0, 7));
    a  = 16'($urandom);
    b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 300));
    issue(who, op, a, b);
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    resp0_ready = 1; resp1_ready = 1;
    model_reset();
    #13;
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_result", resp0_result, 0);
    rst_n = 1'b1;
    step();

    // add 3+5 from req0
    issue(0, 3'd0, 16'd3, 16'd5);
    repeat (4) step();

    // both valid continuously: grants alternate starting with req0
    do_reset();
    g = grant_log.size();
    fork
      begin repeat (4) issue(0, 3'd1, 16'd7, 16'd7); end
      begin repeat (4) issue(1, 3'd4, 16'd0, 16'd0); end
    join
    repeat (4) step();
    for (int i = 0; i < 8; i++) chk("alternate_grant", grant_log[g + i], i % 2);

    // divides on req1, then illegal op on req0
    issue(1, 3'd3, 16'd100, 16'd7);
    repeat (6) step();
    issue(1, 3'd3, 16'd5, 16'd0);
    repeat (6) step();
    issue(0, 3'd7, 16'd9, 16'd9);
    repeat (3) step();

    // response back-pressure holds data and blocks the other requester
    resp0_ready = 0;
    issue(0, 3'd0, 16'd1, 16'd2);
    fork
      begin issue(1, 3'd0, 16'd4, 16'd4); end
      begin
        repeat (10) step();
        chk("hold_resp0_valid", resp0_valid, 1);
        chk("hold_req1_ready", req1_ready, 0);
        resp0_ready = 1;
      end
    join
    repeat (3) step();

    // async reset in the middle of a multiply
    issue(0, 3'd2, 16'd300, 16'd300);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_resp0_valid", resp0_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_flags", {resp0_zero, resp0_err, resp1_zero, resp1_err}, 0);
    chk("mid_rst_result", resp1_result, 0);
    req0_valid = 1;
    #1;
    chk("mid_rst_req0_ready", req0_ready, 0);
    req0_valid = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) step();
    g = grant_log.size();
    fork
      issue(0, 3'd0, 16'd1, 16'd1);
      issue(1, 3'd0, 16'd2, 16'd2);
    join
    repeat (3) step();
    chk("post_rst_first_tie", grant_log[g], 0);

    // randomized traffic with random response back-pressure
    done_cnt = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) step();
          rand_req(0);
        end
        done_cnt++;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) step();
          rand_req(1);
        end
        done_cnt++;
      end
      begin
        while (done_cnt < 2) begin
          step();
          resp0_ready = ($urandom_range(0, 3) != 0);
          resp1_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    resp0_ready = 1;
    resp1_ready = 1;
    repeat (20) step();
    chk("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
